// File: rtl/comm_xtalk_trig.sv
// ---------------------------------------------------------------------------
// comm_xtalk_trig
//   Per-channel edge counter with terminal-count trigger and post-trigger
//   holdoff. Each monitored level is synchronised by a 3-flop chain. Edges of
//   the selected polarity are counted. When the count reaches term_count
//   (0 means 2^CNT_W), the channel emits a one-cycle trigger. It then ignores
//   edges for `holdoff` cycles and flags any edge that arrives in that window.
//
// Ports
//   inclk       system clock (rising edge)
//   rst_n       asynchronous active-low reset
//   sig_in      [N_CH]        asynchronous monitored levels
//   enable      [N_CH]        per-channel run enable
//   edge_mode   [2]           00 rise, 01 fall, 10 both, 11 none
//   term_count  [CNT_W]       edges per trigger, 0 = 2^CNT_W
//   holdoff     [HOLD_W]      cycles to ignore edges after a trigger
//   clear       [1]           synchronous clear of count/holdoff/missed
//   trig        [N_CH]        one-cycle trigger pulse
//   trig_any    [1]           OR of trig
//   count       [N_CH*CNT_W]  per-channel edge count, channel i at [i*CNT_W +: CNT_W]
//   busy        [N_CH]        channel in HOLD
//   missed      [N_CH]        sticky: an edge arrived during HOLD
// ---------------------------------------------------------------------------
module comm_xtalk_trig #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 12,
  parameter int HOLD_W = 8
) (
  input  logic                   inclk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        sig_in,
  input  logic [N_CH-1:0]        enable,
  input  logic [1:0]             edge_mode,
  input  logic [CNT_W-1:0]       term_count,
  input  logic [HOLD_W-1:0]      holdoff,
  input  logic                   clear,
  output logic [N_CH-1:0]        trig,
  output logic                   trig_any,
  output logic [N_CH*CNT_W-1:0]  count,
  output logic [N_CH-1:0]        busy,
  output logic [N_CH-1:0]        missed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  logic [N_CH-1:0]   s0_q, s1_q, s2_q;
  logic [N_CH-1:0]   s0_d, s1_d, s2_d;
  state_t            state_q [N_CH];
  state_t            state_d [N_CH];
  logic [CNT_W-1:0]  count_q [N_CH];
  logic [CNT_W-1:0]  count_d [N_CH];
  logic [HOLD_W-1:0] hold_q  [N_CH];
  logic [HOLD_W-1:0] hold_d  [N_CH];
  logic [N_CH-1:0]   trig_q, trig_d;
  logic [N_CH-1:0]   busy_q, busy_d;
  logic [N_CH-1:0]   missed_q, missed_d;
  logic              trig_any_q, trig_any_d;

  logic [N_CH-1:0]   rise_s, fall_s, edge_s;
  logic [CNT_W:0]    term_ext_s;
  logic [CNT_W:0]    next_cnt_s [N_CH];

  // Edge decode on the synchronised pair and terminal value in CNT_W+1 bits
  always_comb begin
    rise_s = s1_q & ~s2_q;
    fall_s = ~s1_q & s2_q;
    case (edge_mode)
      2'b00:   edge_s = rise_s;
      2'b01:   edge_s = fall_s;
      2'b10:   edge_s = rise_s | fall_s;
      2'b11:   edge_s = {N_CH{1'b0}};
      default: edge_s = {N_CH{1'b0}};
    endcase
    // term_count==0 selects 2^CNT_W, which only the carry-out can reach
    if (term_count == {CNT_W{1'b0}}) begin
      term_ext_s = {1'b1, {CNT_W{1'b0}}};
    end else begin
      term_ext_s = {1'b0, term_count};
    end
  end

  // Per-channel next-state: synchroniser shift, IDLE/COUNT/HOLD control
  always_comb begin
    s0_d = sig_in;
    s1_d = s0_q;
    s2_d = s1_q;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]    = state_q[i];
      count_d[i]    = count_q[i];
      hold_d[i]     = hold_q[i];
      trig_d[i]     = 1'b0;
      missed_d[i]   = missed_q[i];
      next_cnt_s[i] = {1'b0, count_q[i]} + (CNT_W+1)'(1'b1);

      if (!enable[i]) begin
        // Disabled: park in IDLE; missed survives unless explicitly cleared
        state_d[i] = ST_IDLE;
        count_d[i] = {CNT_W{1'b0}};
        hold_d[i]  = {HOLD_W{1'b0}};
        if (clear) begin
          missed_d[i] = 1'b0;
        end else begin
          missed_d[i] = missed_q[i];
        end
      end else if (clear) begin
        // clear wins over any edge or terminal event in the same cycle
        state_d[i]  = ST_COUNT;
        count_d[i]  = {CNT_W{1'b0}};
        hold_d[i]   = {HOLD_W{1'b0}};
        missed_d[i] = 1'b0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            state_d[i] = ST_COUNT;
          end
          ST_COUNT: begin
            if (edge_s[i]) begin
              // Exact match only: a count already past a lowered term_count
              // keeps incrementing until it wraps.
              if (next_cnt_s[i] == term_ext_s) begin
                count_d[i] = {CNT_W{1'b0}};
                trig_d[i]  = 1'b1;
                if (holdoff != {HOLD_W{1'b0}}) begin
                  state_d[i] = ST_HOLD;
                  hold_d[i]  = holdoff;
                end else begin
                  state_d[i] = ST_COUNT;
                end
              end else begin
                count_d[i] = next_cnt_s[i][CNT_W-1:0];
              end
            end else begin
              count_d[i] = count_q[i];
            end
          end
          ST_HOLD: begin
            if (edge_s[i]) begin
              missed_d[i] = 1'b1;
            end else begin
              missed_d[i] = missed_q[i];
            end
            // hold_q holds the cycles left including the current one
            if (hold_q[i] <= HOLD_W'(1'b1)) begin
              state_d[i] = ST_COUNT;
              hold_d[i]  = {HOLD_W{1'b0}};
            end else begin
              hold_d[i]  = hold_q[i] - HOLD_W'(1'b1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            count_d[i] = {CNT_W{1'b0}};
            hold_d[i]  = {HOLD_W{1'b0}};
          end
        endcase
      end
      busy_d[i] = (state_d[i] == ST_HOLD);
    end
    trig_any_d = |trig_d;
  end

  // State and output registers, asynchronously reset
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q       <= {N_CH{1'b0}};
      s1_q       <= {N_CH{1'b0}};
      s2_q       <= {N_CH{1'b0}};
      trig_q     <= {N_CH{1'b0}};
      busy_q     <= {N_CH{1'b0}};
      missed_q   <= {N_CH{1'b0}};
      trig_any_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        count_q[i] <= {CNT_W{1'b0}};
        hold_q[i]  <= {HOLD_W{1'b0}};
      end
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      missed_q   <= missed_d;
      trig_any_q <= trig_any_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  assign trig     = trig_q;
  assign trig_any = trig_any_q;
  assign busy     = busy_q;
  assign missed   = missed_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_count
    assign count[g*CNT_W +: CNT_W] = count_q[g];
  end

endmodule

// File: doc/comm_xtalk_trig.md
COMM_XTALK_TRIG -- requirements
Module: comm_xtalk_trig

Interface
REQ-001 Parameter N_CH, default 4: number of independent monitored channels (1..16).
REQ-002 Parameter CNT_W, default 12: edge-counter width per channel (4..24).
REQ-003 Parameter HOLD_W, default 8: holdoff-counter width.
REQ-004 inclk  input  1  system clock, 20 MHz; all state SHALL change only on its rising edge, except asynchronous reset.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 sig_in  input  N_CH  asynchronous monitored levels, e.g. comm_dac_on per channel.
REQ-007 enable  input  N_CH  per-channel run enable.
REQ-008 edge_mode  input  2  counted edge: 00 rising, 01 falling, 10 both, 11 none.
REQ-009 term_count  input  CNT_W  edges per trigger; 0 means 2^CNT_W.
REQ-010 holdoff  input  HOLD_W  cycles during which edges are ignored after a trigger.
REQ-011 clear  input  1  synchronous clear of counters, holdoff and missed flags on all channels.
REQ-012 trig  output  N_CH  registered one-cycle trigger pulse per channel.
REQ-013 trig_any  output  1  OR of trig, same cycle as trig.
REQ-014 count  output  N_CH*CNT_W  registered edge count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-015 busy  output  N_CH  high while the channel is in HOLD.
REQ-016 missed  output  N_CH  sticky flag: an edge was detected during HOLD.

Function
REQ-017 Each sig_in bit SHALL pass through a 3-flop chain s0->s1->s2 that runs regardless of enable; the edge is decoded from s1 versus s2.
REQ-018 A level change sampled at clock edge k SHALL update count at clock edge k+2.
REQ-019 Each channel SHALL implement the states IDLE, COUNT and HOLD.
REQ-020 IDLE: count=0, trig=0, busy=0; IDLE->COUNT on the first cycle enable[i]=1.
REQ-021 From any state, enable[i]=0 SHALL force IDLE on the next edge and clear count and the holdoff counter; missed SHALL be retained.
REQ-022 COUNT: each accepted edge SHALL increment count by 1, modulo 2^CNT_W arithmetic.
REQ-023 Terminal edge: an edge that would make count equal to the terminal value (term_count, or 2^CNT_W when term_count=0) SHALL instead set count=0 and trig[i]=1 on that same clock edge.
REQ-024 After a terminal edge, the channel SHALL enter HOLD if holdoff!=0, otherwise remain in COUNT.
REQ-025 HOLD SHALL last exactly holdoff cycles, starting with the trig-high cycle, then return to COUNT; holdoff is sampled on entry to HOLD.
REQ-026 In HOLD, detected edges SHALL NOT be counted and SHALL set missed[i]=1.
REQ-027 With holdoff=0, an edge detected in the trig-high cycle SHALL be counted, giving count=1.
REQ-028 trig SHALL be high for exactly one cycle per terminal edge.
REQ-029 Back-to-back terminal edges on consecutive cycles (term_count=1, holdoff=0, edge_mode=10) SHALL produce trig high on consecutive cycles.
REQ-030 edge_mode=11 SHALL count nothing and SHALL NOT set missed.
REQ-031 Changes to edge_mode or term_count SHALL take effect on the next cycle.
REQ-032 If term_count is lowered to or below the current count, the next accepted edge SHALL simply increment, and no trigger SHALL fire until the count wraps.
REQ-033 clear SHALL take priority over a simultaneous edge or terminal event: count=0, trig=0, missed=0, HOLD->COUNT (IDLE if disabled).
REQ-034 Channels SHALL be fully independent; simultaneous triggers on several channels SHALL all be reported.

Reset
REQ-035 rst_n=0 SHALL immediately force, on all channels: s0/s1/s2=0, state=IDLE, count=0, trig=0, trig_any=0, busy=0, missed=0.
REQ-036 On reset release, a channel whose sig_in is held high SHALL see one rising edge; this is accepted behaviour, and the bench SHALL account for it.
REQ-037 Reset asserted mid-HOLD or mid-pulse SHALL abort without completing the trig pulse.

Verification
REQ-038 CNT_W=12, term_count=0, rising mode, 4096 pulses on ch0 -> single trig[0] on the 4096th pulse, at input-sample edge +2; count returns to 0; trig_any high for the same cycle.
REQ-039 term_count=5, holdoff=10, 7 pulses spaced 4 cycles -> trig on pulse 5; pulses 6-7 fall in HOLD: count=0, missed=1, busy high for 10 cycles.
REQ-040 term_count=1, holdoff=0, both mode, sig_in toggling every cycle -> trig high every cycle; count stays 0.
REQ-041 clear asserted on the cycle of the terminal edge (term_count=3) -> trig stays 0 and count=0.
REQ-042 ch0 and ch3 reach term_count=2 on the same cycle -> trig=4'b1001 and trig_any=1 for one cycle.
REQ-043 rst_n pulsed low during HOLD with count=7 on ch1 -> all outputs 0 immediately; after release and enable, counting restarts from 0.
